// File: rtl/sm4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm4_pkg                                                         |
// | Brief    : Shared helpers and payload type for the dynamic rotate pipeline |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sm4_pkg;

  localparam int c_roll_width     = 32;
  localparam int c_roll_shamt_w   = $clog2(c_roll_width);
  localparam int c_roll_tag_width = 4;

  // Payload layout of one stage in the default 32-bit configuration.
  typedef struct packed {
    logic [c_roll_width-1:0]     data;
    logic [c_roll_shamt_w-1:0]   shamt;
    logic                        left;
    logic [c_roll_tag_width-1:0] tag;
  } roll_payload_t;

  function automatic int roll_layer_stage(input int k, input int layers, input int stages);
    return (k * stages) / layers;
  endfunction

  function automatic int roll_layer_amt(input int k, input int width);
    return (1 << k) % width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/roll_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : roll_stage                                                      |
// | Brief    : One pipeline register stage with its assigned rotate layers     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module roll_stage
  import sm4_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int stages_p    = 2,
  parameter int tag_width_p = 4,
  parameter int stage_idx_p = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       i_advance,
  input  logic                       i_valid,
  input  logic [width_p-1:0]         i_data,
  input  logic [$clog2(width_p)-1:0] i_shamt,
  input  logic                       i_left,
  input  logic [tag_width_p-1:0]     i_tag,
  output logic                       o_valid,
  output logic [width_p-1:0]         o_data,
  output logic [$clog2(width_p)-1:0] o_shamt,
  output logic                       o_left,
  output logic [tag_width_p-1:0]     o_tag
);

  localparam int c_layers = $clog2(width_p);

  typedef struct packed {
    logic [width_p-1:0]     data;
    logic [c_layers-1:0]    shamt;
    logic                   left;
    logic [tag_width_p-1:0] tag;
  } payload_t;

  payload_t           r_pl;
  logic               r_valid;
  logic [width_p-1:0] w_rot;

  function automatic logic [width_p-1:0] rotl(input logic [width_p-1:0] x, input int amt);
    logic [2*width_p-1:0] dbl;
    dbl = {x, x} << amt;
    return dbl[2*width_p-1:width_p];
  endfunction

  // Right rotation by a is done as left rotation by width_p - a.
  always_comb begin
    w_rot = i_data;
    for (int k = 0; k < c_layers; k++) begin
      if ((roll_layer_stage(k, c_layers, stages_p) == stage_idx_p) && i_shamt[k]) begin
        w_rot = rotl(w_rot, i_left ? roll_layer_amt(k, width_p)
                                   : width_p - roll_layer_amt(k, width_p));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_pl    <= '0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_pl.data  <= w_rot;
        r_pl.shamt <= i_shamt;
        r_pl.left  <= i_left;
        r_pl.tag   <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_pl.data;
  assign o_shamt = r_pl.shamt;
  assign o_left  = r_pl.left;
  assign o_tag   = r_pl.tag;

endmodule
`default_nettype wire

// File: rtl/dyn_roll_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dyn_roll_shifter                                                |
// | Brief    : Pipelined runtime-amount rotate unit with valid/ready handshake |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dyn_roll_shifter
  import sm4_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int stages_p    = 2,
  parameter int tag_width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [width_p-1:0]         data_i,
  input  logic [$clog2(width_p)-1:0] shamt_i,
  input  logic                       left_i,
  input  logic [tag_width_p-1:0]     tag_i,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o,
  output logic [tag_width_p-1:0]     tag_o
);

  localparam int c_shamt_w = $clog2(width_p);

  // Index 0 is the input port; index s+1 is the output of stage s.
  logic [stages_p:0]      w_valid;
  logic [width_p-1:0]     w_data  [stages_p+1];
  logic [c_shamt_w-1:0]   w_shamt [stages_p+1];
  logic [stages_p:0]      w_left;
  logic [tag_width_p-1:0] w_tag   [stages_p+1];
  logic [stages_p-1:0]    w_adv;
  logic                   w_unused_tail;

  assign w_valid[0] = v_i;
  assign w_data[0]  = data_i;
  assign w_shamt[0] = shamt_i;
  assign w_left[0]  = left_i;
  assign w_tag[0]   = tag_i;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    w_adv = '0;
    w_adv[stages_p-1] = ~w_valid[stages_p] | ready_i;
    for (int s = stages_p - 2; s >= 0; s--) begin
      w_adv[s] = ~w_valid[s+1] | w_adv[s+1];
    end
  end

  for (genvar s = 0; s < stages_p; s++) begin : g_stage
    roll_stage #(
      .width_p     (width_p),
      .stages_p    (stages_p),
      .tag_width_p (tag_width_p),
      .stage_idx_p (s)
    ) u_stage (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .i_advance (w_adv[s]),
      .i_valid   (w_valid[s]),
      .i_data    (w_data[s]),
      .i_shamt   (w_shamt[s]),
      .i_left    (w_left[s]),
      .i_tag     (w_tag[s]),
      .o_valid   (w_valid[s+1]),
      .o_data    (w_data[s+1]),
      .o_shamt   (w_shamt[s+1]),
      .o_left    (w_left[s+1]),
      .o_tag     (w_tag[s+1])
    );
  end

  assign w_unused_tail = ^{w_shamt[stages_p], w_left[stages_p]};

  assign ready_o = w_adv[0];
  assign v_o     = w_valid[stages_p];
  assign data_o  = w_data[stages_p];
  assign tag_o   = w_tag[stages_p];

endmodule
`default_nettype wire

// File: tb/tb_dyn_roll_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dyn_roll_shifter                                             |
// | Brief    : Self-checking bench for dyn_roll_shifter in four configurations |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dyn_roll_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One stimulus set, steered to the selected instance.
  logic [1:0]  sel = 2'd0;
  int          cur_w = 32;
  int          cur_s = 2;
  logic        v = 1'b0, left = 1'b0, rdy = 1'b0;
  logic [31:0] din = '0;
  logic [4:0]  sh = '0;
  logic [3:0]  tg = '0;
  logic [3:0]  dv, dr;

  assign dv = v   ? (4'b0001 << sel) : 4'b0000;
  assign dr = rdy ? (4'b0001 << sel) : 4'b0000;

  logic        a_v, b_v, c_v, d_v;
  logic        a_rdy, b_rdy, c_rdy, d_rdy;
  logic [31:0] a_data, c_data, d_data;
  logic [23:0] b_data;
  logic [3:0]  a_tag, b_tag, c_tag, d_tag;

  logic        m_v, m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_tag;

  always_comb begin
    m_v = a_v; m_ready = a_rdy; m_data = a_data; m_tag = a_tag;
    case (sel)
      2'd1: begin m_v = b_v; m_ready = b_rdy; m_data = {8'h00, b_data}; m_tag = b_tag; end
      2'd2: begin m_v = c_v; m_ready = c_rdy; m_data = c_data; m_tag = c_tag; end
      2'd3: begin m_v = d_v; m_ready = d_rdy; m_data = d_data; m_tag = d_tag; end
      default: ;
    endcase
  end

  dyn_roll_shifter #(.width_p(32), .stages_p(2), .tag_width_p(4)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .v_i(dv[0]), .ready_o(a_rdy), .data_i(din),
    .shamt_i(sh), .left_i(left), .tag_i(tg), .v_o(a_v), .ready_i(dr[0]),
    .data_o(a_data), .tag_o(a_tag));

  dyn_roll_shifter #(.width_p(24), .stages_p(3), .tag_width_p(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .v_i(dv[1]), .ready_o(b_rdy), .data_i(din[23:0]),
    .shamt_i(sh), .left_i(left), .tag_i(tg), .v_o(b_v), .ready_i(dr[1]),
    .data_o(b_data), .tag_o(b_tag));

  dyn_roll_shifter #(.width_p(32), .stages_p(1), .tag_width_p(4)) u_dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .v_i(dv[2]), .ready_o(c_rdy), .data_i(din),
    .shamt_i(sh), .left_i(left), .tag_i(tg), .v_o(c_v), .ready_i(dr[2]),
    .data_o(c_data), .tag_o(c_tag));

  dyn_roll_shifter #(.width_p(32), .stages_p(5), .tag_width_p(4)) u_dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .v_i(dv[3]), .ready_o(d_rdy), .data_i(din),
    .shamt_i(sh), .left_i(left), .tag_i(tg), .v_o(d_v), .ready_i(dr[3]),
    .data_o(d_data), .tag_o(d_tag));

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  // Bit-level rotate straight from the index formulas.
  function automatic logic [31:0] ref_rot(input logic [31:0] d, input int s, input bit lft, input int w);
    logic [31:0] r;
    int a;
    r = '0;
    a = s % w;
    for (int j = 0; j < w; j++) r[j] = lft ? d[(j - a + w) % w] : d[(j + a) % w];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] s, input int w, input int st);
    sel = s; cur_w = w; cur_s = st;
  endtask

  task automatic test_reset();
    select(2'd0, 32, 2);
    v = 1'b0; rdy = 1'b1;
    rst_n = 1'b0;
    #12;
    n_tests++; if (m_v !== 1'b0)     begin n_fail++; $display("FAIL reset_v: got %0b want 0", m_v); end
    n_tests++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
    n_tests++; if (m_tag !== 4'h0)   begin n_fail++; $display("FAIL reset_tag: got %h want 0", m_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (m_v !== 1'b0 || m_data !== 32'h0 || m_tag !== 4'h0) begin
      n_fail++; $display("FAIL post_reset_out: got v=%0b d=%h t=%h want 0/0/0", m_v, m_data, m_tag);
    end
    n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %0b want 1", m_ready); end
    step();
  endtask

  task automatic test_directed();
    logic [31:0] exp_d;
    logic [3:0]  exp_t4;
    select(2'd0, 32, 2);
    rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_d  = (i == 0) ? 32'h0000_0003 : 32'hC000_0000;
      exp_t4 = 4'(i + 5);
      v = 1'b1; din = 32'h8000_0001; sh = 5'd1; left = (i == 0); tg = exp_t4;
      #1;
      n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready: got %0b want 1", m_ready); end
      step();
      v = 1'b0; din = 'x;
      #1;
      n_tests++; if (m_v !== 1'b0) begin n_fail++; $display("FAIL dir_early_v: got %0b want 0", m_v); end
      step();
      #1;
      n_tests++; if (m_v !== 1'b1 || m_data !== exp_d || m_tag !== exp_t4) begin
        n_fail++; $display("FAIL dir_out%0d: got v=%0b d=%h t=%h want 1/%h/%h", i, m_v, m_data, m_tag, exp_d, exp_t4);
      end
      step();
    end
  endtask

  // Generic random scenario with scoreboard; vp/rp are percent chances of v_i/ready_i.
  task automatic test_stream(input int n, input int vp, input int rp, output int cycles);
    exp_t sb[$];
    exp_t e;
    int sent, cyc;
    bit held;
    logic [31:0] hd;
    logic [3:0]  ht;
    sent = 0; cyc = 0; held = 1'b0; hd = '0; ht = '0;
    while ((sent < n || sb.size() != 0) && cyc < 4000) begin
      v = (sent < n) && ($urandom_range(99) < vp);
      din = $urandom;
      if (cur_w < 32) din = din & ((32'd1 << cur_w) - 1);
      sh = 5'($urandom); left = 1'($urandom); tg = 4'($urandom);
      rdy = ($urandom_range(99) < rp);
      #1;
      n_tests++;
      if (m_ready !== ((sb.size() < cur_s) || rdy)) begin
        n_fail++; $display("FAIL stream_ready: got %0b want %0b (occ=%0d)", m_ready, (sb.size() < cur_s) || rdy, sb.size());
      end
      if (sb.size() == 0) begin
        n_tests++; if (m_v !== 1'b0) begin n_fail++; $display("FAIL stream_empty_v: got %0b want 0", m_v); end
      end
      if (held) begin
        n_tests++; if (m_v !== 1'b1 || m_data !== hd || m_tag !== ht) begin
          n_fail++; $display("FAIL stream_stall: got v=%0b d=%h t=%h want 1/%h/%h", m_v, m_data, m_tag, hd, ht);
        end
      end
      if (m_v === 1'b1 && rdy && sb.size() != 0) begin
        e = sb.pop_front();
        n_tests++; if (m_data !== e.d || m_tag !== e.t) begin
          n_fail++; $display("FAIL stream_data: got d=%h t=%h want %h/%h", m_data, m_tag, e.d, e.t);
        end
      end
      held = (m_v === 1'b1) && !rdy;
      hd = m_data; ht = m_tag;
      if (v && m_ready === 1'b1) begin
        sb.push_back('{ref_rot(din, int'(sh), left, cur_w), tg});
        sent++;
      end
      step();
      cyc++;
    end
    v = 1'b0; rdy = 1'b1; din = 'x;
    if (cyc >= 4000) begin
      n_tests++; n_fail++; $display("FAIL stream_timeout: got %0d left want 0", sb.size());
    end
    cycles = cyc;
  endtask

  task automatic test_back_to_back();
    int cyc;
    select(2'd0, 32, 2);
    test_stream(100, 100, 100, cyc);
    n_tests++; if (cyc != 100 + 2) begin n_fail++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, 102); end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int acc, outs;
    select(2'd0, 32, 2);
    acc = 0; outs = 0; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = 1'b1; din = $urandom; sh = 5'($urandom); left = 1'($urandom); tg = 4'($urandom);
      #1;
      if (m_ready === 1'b1) begin
        q.push_back('{ref_rot(din, int'(sh), left, 32), tg});
        acc++;
      end
      if (i >= 2) begin
        n_tests++; if (m_v !== 1'b1 || m_data !== q[0].d || m_tag !== q[0].t) begin
          n_fail++; $display("FAIL bp_hold: got v=%0b d=%h t=%h want 1/%h/%h", m_v, m_data, m_tag, q[0].d, q[0].t);
        end
      end
      step();
    end
    v = 1'b0; din = 'x;
    #1;
    n_tests++; if (acc != 2)          begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    n_tests++; if (m_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_ready: got %0b want 0", m_ready); end
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (m_v === 1'b1) begin
        outs++;
        if (q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL bp_dup: got extra word %h want none", m_data);
        end else begin
          e = q.pop_front();
          n_tests++; if (m_data !== e.d || m_tag !== e.t) begin
            n_fail++; $display("FAIL bp_drain: got d=%h t=%h want %h/%h", m_data, m_tag, e.d, e.t);
          end
        end
      end
      step();
    end
    n_tests++; if (outs != 2) begin n_fail++; $display("FAIL bp_outs: got %0d want 2", outs); end
  endtask

  task automatic test_non_pow2();
    logic [31:0] rd;
    int cyc;
    select(2'd1, 24, 3);
    rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd = (i == 0) ? 32'h0000_0001 : ($urandom & 32'h00FF_FFFF);
      v = 1'b1; din = rd; sh = (i == 0) ? 5'd31 : 5'd0; left = 1'b1; tg = 4'hA;
      step();
      v = 1'b0; din = 'x;
      #1;
      n_tests++; if (m_v !== 1'b0) begin n_fail++; $display("FAIL np2_early1: got %0b want 0", m_v); end
      step();
      #1;
      n_tests++; if (m_v !== 1'b0) begin n_fail++; $display("FAIL np2_early2: got %0b want 0", m_v); end
      step();
      #1;
      if (i == 0) rd = 32'h0000_0080;
      n_tests++; if (m_v !== 1'b1 || m_data !== rd || m_tag !== 4'hA) begin
        n_fail++; $display("FAIL np2_out%0d: got v=%0b d=%h t=%h want 1/%h/a", i, m_v, m_data, m_tag, rd);
      end
      step();
    end
    test_stream(60, 70, 60, cyc);
  endtask

  task automatic test_reset_mid();
    select(2'd0, 32, 2);
    rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v = 1'b1; din = $urandom; sh = 5'($urandom); left = 1'($urandom); tg = 4'($urandom);
      step();
    end
    v = 1'b0; din = 'x;
    rst_n = 1'b0;
    #1;
    n_tests++; if (m_v !== 1'b0 || m_data !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_out: got v=%0b d=%h want 0/0", m_v, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++; if (m_v !== 1'b0 || m_ready !== 1'b1) begin
        n_fail++; $display("FAIL mid_reset_stale: got v=%0b rdy=%0b want 0/1", m_v, m_ready);
      end
      step();
    end
  endtask

  task automatic test_random_ready();
    int cyc;
    select(2'd2, 32, 1);
    test_stream(80, 60, 50, cyc);
    select(2'd3, 32, 5);
    test_stream(80, 60, 50, cyc);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_non_pow2();
    test_reset_mid();
    test_random_ready();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dyn_roll_shifter.md
Name: dyn_roll_shifter

Overview:
- Runtime-controlled, pipelined rotate unit: rotates a width_p-bit word left or right by a per-transaction amount.
- Successor to the static-amount rotator: amount and direction are inputs, width is generic (not limited to powers of two), and the datapath is split over stages_p register stages with valid/ready flow control.
- Sits between SM4 round-function producers and consumers, wherever rotate amounts are data- or mode-dependent.

Parameters:
width_p, 32, data width in bits; legal values are 2 or more.
stages_p, 2, number of register stages (latency); legal range is 1..$clog2(width_p).
tag_width_p, 4, width of the sideband tag carried alongside the data.

Ports:
clk_i  in  1  clock; all state is updated on the rising edge.
rst_n_i  in  1  asynchronous active-low reset.
v_i  in  1  input valid.
ready_o  out  1  input ready.
data_i  in  width_p  word to rotate.
shamt_i  in  $clog2(width_p)  rotate amount.
left_i  in  1  direction select: 1 = rotate left, 0 = rotate right.
tag_i  in  tag_width_p  sideband tag, passed through unchanged.
v_o  out  1  output valid.
ready_i  in  1  downstream ready.
data_o  out  width_p  rotated word.
tag_o  out  tag_width_p  tag of the word currently on data_o.

Behaviour:
Function:
- Left rotate: data_o[j] = data_i[(j - s + width_p) % width_p], where s = shamt_i % width_p.
- Right rotate: data_o[j] = data_i[(j + s) % width_p].
- shamt_i values of width_p or more are legal and rotate by shamt_i mod width_p (relevant only when width_p is not a power of two).
- shamt_i = 0 passes data through unchanged.

Datapath:
- L = $clog2(width_p) layers. Layer k rotates by (2^k mod width_p) when shamt bit k is set, in the direction given by the transaction's left bit.
- Layer k sits in stage floor(k*stages_p/L).
- Direction, remaining shamt bits and tag are registered with the data at every stage.

Pipeline and handshake:
- Each stage holds one valid bit plus a payload.
- A stage advances when it is empty or the next stage advances; the last stage advances when ready_i is high.
- ready_o = ~valid[0] | advance[0]. This is combinational from ready_i (no skid buffer).
- Transfers happen when v_i & ready_o at the input, and when v_o & ready_i at the output.
- Latency is exactly stages_p cycles from input accept to v_o when unstalled.
- Throughput is one word per cycle when ready_i is held high.
- While v_o & ~ready_i, data_o and tag_o stay stable and no stage overwrites a valid, unadvanced entry.
- The pipeline holds at most stages_p words. ready_o drops only when every stage is valid and ready_i is low.
- Bubbles collapse: an empty middle stage accepts from upstream even while the output is stalled.

Reset:
- rst_n_i low clears all valid bits immediately (asynchronous). v_o = 0, data_o = 0, tag_o = 0 while in reset and on the first cycle after it.
- ready_o is 1 after reset.
- In-flight words are discarded on reset mid-operation; none reappear after reset is released.

Boundary and illegal use:
- v_i must not depend on ready_o.
- Inputs are ignored when v_i = 0.
- X on data_i with v_i = 0 must not propagate to v_o.

Decomposition:
- Package sm4_pkg:
  - function roll_layer_stage(k, layers, stages) returning the stage index for layer k;
  - function roll_layer_amt(k, width) returning 2^k mod width;
  - a typedef for the per-stage payload struct {data, shamt, left, tag}.
- Sub-module roll_stage: one register stage with its assigned set of conditional rotate layers, valid bit and advance logic.
- dyn_roll_shifter instantiates stages_p roll_stage instances via generate.

Test Plan:
1. width_p=32, stages_p=2, ready_i=1: data 0x80000001, shamt 1, left -> data_o 0x00000003 two cycles later. Same data, shamt 1, right -> 0xC0000000.
2. Back-to-back stream of 100 random (data, shamt, dir, tag) with ready_i=1 -> one output per cycle, in order, tags matching, results matching the reference model.
3. Backpressure: ready_i=0 for 5 cycles while v_i=1 -> exactly 2 words accepted, ready_o=0 afterwards, data_o and tag_o stable. On ready_i=1 the words drain in order with no loss or duplication.
4. width_p=24, stages_p=3: data 0x000001, shamt 31, left -> 0x000080 (rotate by 7). shamt 0 -> passthrough.
5. Reset mid-operation: assert rst_n_i with 2 words in flight -> v_o=0 immediately. After release, no stale output appears and ready_o=1.
6. Random ready_i toggling and bubbles, stages_p=1 and stages_p=$clog2(width_p) -> scoreboard match, and no output while the pipeline is empty.
